// File: rtl/bnn_seq_pkg.sv
// Shared types and constants for the BNN bring-up sequencer.
package bnn_seq_pkg;

    // Top-level sequencer states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_INST,
        ST_LOAD_DATA,
        ST_RUN,
        ST_READOUT,
        ST_DONE
    } seq_state_t;

    // Slot offsets at which the serializer load and the SRAM enable fall
    localparam int PSL_OFS = 3;
    localparam int CEN_OFS = 5;

    // Default image sizes, slot timing and addresses for the board build
    localparam int DEF_ADDR_W       = 14;
    localparam int DEF_INST_WORDS   = 521;
    localparam int DEF_DATA_WORDS   = 12266;
    localparam int DEF_SLOT_CYCLES  = 41;
    localparam int DEF_INST_CEN_LEN = 17;
    localparam int DEF_DATA_CEN_LEN = 33;
    localparam int DEF_RUN_ADDR     = 5000;
    localparam int DEF_RUN_CYCLES   = 648324;
    localparam int DEF_READ_BASE    = 2000;
    localparam int DEF_READ_ROWS    = 8;
    localparam int DEF_ROW_CYCLES   = 34;

endpackage

// File: rtl/bnn_slot_gen.sv
// Per-word slot timer: counts 0..SLOT_CYCLES-1 and flags the slot
// positions where the sequencer changes the SRAM/serializer controls.
module bnn_slot_gen
    import bnn_seq_pkg::*;
#(
    parameter int SLOT_CYCLES = DEF_SLOT_CYCLES,
    parameter int SLOT_W      = $clog2(SLOT_CYCLES)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              clr,
    input  logic              en,
    input  logic [SLOT_W-1:0] cen_len,
    output logic              stb_addr,
    output logic              stb_psl,
    output logic              stb_cen_on,
    output logic              stb_cen_off,
    output logic              stb_end
);

    localparam logic [SLOT_W:0]   CEN_FALL = (SLOT_W+1)'(CEN_OFS);
    localparam logic [SLOT_W-1:0] PSL_FALL = SLOT_W'(PSL_OFS);
    localparam logic [SLOT_W-1:0] SLOT_END = SLOT_W'(SLOT_CYCLES - 1);

    logic [SLOT_W-1:0] slot_cnt;
    logic [SLOT_W:0]   cen_rise;

    // Slot counter wraps at the end of every slot so back-to-back words share it
    always_ff @(posedge CLK) begin
        if (RST || clr) begin
            slot_cnt <= '0;
        end else if (en) begin
            slot_cnt <= stb_end ? '0 : slot_cnt + SLOT_W'(1);
        end
    end

    // Strobes only fire while the slot timer is actually running
    always_comb begin
        cen_rise    = CEN_FALL + {1'b0, cen_len};
        stb_addr    = en && (slot_cnt == '0);
        stb_psl     = en && (slot_cnt == PSL_FALL);
        stb_cen_on  = en && ({1'b0, slot_cnt} == CEN_FALL);
        stb_cen_off = en && ({1'b0, slot_cnt} == cen_rise);
        stb_end     = en && (slot_cnt == SLOT_END);
    end

endmodule

// File: rtl/bnn_load_seq.sv
// Bring-up sequencer for the BNN accelerator: loads the instruction and
// data images through the serial SRAM port, lets the network run, then
// reads back the FC output rows with a TRIGGER window per row.
module bnn_load_seq
    import bnn_seq_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int INST_WORDS   = DEF_INST_WORDS,
    parameter int DATA_WORDS   = DEF_DATA_WORDS,
    parameter int SLOT_CYCLES  = DEF_SLOT_CYCLES,
    parameter int INST_CEN_LEN = DEF_INST_CEN_LEN,
    parameter int DATA_CEN_LEN = DEF_DATA_CEN_LEN,
    parameter int RUN_ADDR     = DEF_RUN_ADDR,
    parameter int RUN_CYCLES   = DEF_RUN_CYCLES,
    parameter int READ_BASE    = DEF_READ_BASE,
    parameter int READ_ROWS    = DEF_READ_ROWS,
    parameter int ROW_CYCLES   = DEF_ROW_CYCLES
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    output logic              BUSY,
    output logic              DONE,
    output logic              PAUSE,
    output logic              SRAMSEL,
    output logic              SRAMMUX,
    output logic [ADDR_W-1:0] SRAMA,
    output logic              SRAMCEN,
    output logic              SRAMWEN,
    output logic              PS_LOADN,
    output logic              TRIGGER,
    output logic [2:0]        FC_ROW
);

    localparam int SLOT_W = $clog2(SLOT_CYCLES);
    localparam int RUN_W  = $clog2(RUN_CYCLES + 1);
    localparam int PH_W   = $clog2(ROW_CYCLES);
    localparam int ROW_W  = $clog2(READ_ROWS + 1);

    localparam logic [ADDR_W-1:0] INST_LAST = ADDR_W'(INST_WORDS - 1);
    localparam logic [ADDR_W-1:0] DATA_LAST = ADDR_W'(DATA_WORDS - 1);
    localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(RUN_CYCLES - 1);
    localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(ROW_CYCLES - 1);
    localparam logic [ROW_W-1:0]  ROWS_END  = ROW_W'(READ_ROWS);

    seq_state_t        state, state_n;
    logic [ADDR_W-1:0] idx, idx_n;
    logic [RUN_W-1:0]  run_cnt, run_n;
    logic [PH_W-1:0]   rd_phase, ph_n;
    logic [ROW_W-1:0]  rd_row, row_n;

    logic              pause_n, sel_n, mux_n, cen_n, wen_n, psl_n, trig_n;
    logic [ADDR_W-1:0] addr_n;
    logic [2:0]        fc_n;

    logic              slot_clr, slot_en;
    logic [SLOT_W-1:0] cen_len;
    logic              stb_addr, stb_psl, stb_cen_on, stb_cen_off, stb_end;

    assign slot_clr = (state == ST_IDLE) || (state == ST_DONE);
    assign slot_en  = (state == ST_LOAD_INST) || (state == ST_LOAD_DATA);
    assign cen_len  = (state == ST_LOAD_DATA) ? SLOT_W'(DATA_CEN_LEN)
                                              : SLOT_W'(INST_CEN_LEN);
    assign BUSY     = (state != ST_IDLE) && (state != ST_DONE);
    assign DONE     = (state == ST_DONE);

    bnn_slot_gen #(
        .SLOT_CYCLES (SLOT_CYCLES),
        .SLOT_W      (SLOT_W)
    ) u_slot (
        .CLK         (CLK),
        .RST         (RST),
        .clr         (slot_clr),
        .en          (slot_en),
        .cen_len     (cen_len),
        .stb_addr    (stb_addr),
        .stb_psl     (stb_psl),
        .stb_cen_on  (stb_cen_on),
        .stb_cen_off (stb_cen_off),
        .stb_end     (stb_end)
    );

    // Registers the FSM state, counters and every output; reset wins everywhere
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= ST_IDLE;
            idx      <= '0;
            run_cnt  <= '0;
            rd_phase <= '0;
            rd_row   <= '0;
            PAUSE    <= 1'b1;
            SRAMSEL  <= 1'b1;
            SRAMMUX  <= 1'b0;
            SRAMA    <= '0;
            SRAMCEN  <= 1'b1;
            SRAMWEN  <= 1'b0;
            PS_LOADN <= 1'b1;
            TRIGGER  <= 1'b0;
            FC_ROW   <= '0;
        end else begin
            state    <= state_n;
            idx      <= idx_n;
            run_cnt  <= run_n;
            rd_phase <= ph_n;
            rd_row   <= row_n;
            PAUSE    <= pause_n;
            SRAMSEL  <= sel_n;
            SRAMMUX  <= mux_n;
            SRAMA    <= addr_n;
            SRAMCEN  <= cen_n;
            SRAMWEN  <= wen_n;
            PS_LOADN <= psl_n;
            TRIGGER  <= trig_n;
            FC_ROW   <= fc_n;
        end
    end

    // Next-state and next-output logic; everything holds unless a phase acts on it
    always_comb begin
        state_n = state;
        idx_n   = idx;
        run_n   = run_cnt;
        ph_n    = rd_phase;
        row_n   = rd_row;
        pause_n = PAUSE;
        sel_n   = SRAMSEL;
        mux_n   = SRAMMUX;
        addr_n  = SRAMA;
        cen_n   = SRAMCEN;
        wen_n   = SRAMWEN;
        psl_n   = PS_LOADN;
        trig_n  = TRIGGER;
        fc_n    = FC_ROW;

        unique case (state)
            ST_IDLE, ST_DONE: begin
                if (START) begin
                    state_n = ST_LOAD_INST;
                    idx_n   = '0;
                    mux_n   = 1'b0;
                end
            end

            ST_LOAD_INST, ST_LOAD_DATA: begin
                if (stb_addr)    addr_n = idx;
                if (stb_psl)     psl_n  = 1'b0;
                if (stb_cen_on)  cen_n  = 1'b0;
                if (stb_cen_off) cen_n  = 1'b1;
                if (stb_end) begin
                    cen_n = 1'b1;
                    wen_n = 1'b0;
                    psl_n = 1'b1;
                    idx_n = idx + ADDR_W'(1);
                    if (state == ST_LOAD_INST && idx == INST_LAST) begin
                        idx_n   = '0;
                        mux_n   = 1'b1;
                        state_n = ST_LOAD_DATA;
                    end else if (state == ST_LOAD_DATA && idx == DATA_LAST) begin
                        idx_n   = '0;
                        pause_n = 1'b0;
                        sel_n   = 1'b0;
                        addr_n  = ADDR_W'(RUN_ADDR);
                        run_n   = '0;
                        state_n = ST_RUN;
                    end
                end
            end

            ST_RUN: begin
                if (run_cnt == RUN_LAST) begin
                    ph_n    = '0;
                    row_n   = '0;
                    state_n = ST_READOUT;
                end else begin
                    run_n = run_cnt + RUN_W'(1);
                end
            end

            ST_READOUT: begin
                if (rd_phase == '0) begin
                    if (rd_row == '0) begin
                        pause_n = 1'b1;
                        sel_n   = 1'b1;
                        wen_n   = 1'b1;
                        addr_n  = ADDR_W'(READ_BASE);
                        fc_n    = '0;
                    end else begin
                        cen_n  = 1'b1;
                        trig_n = 1'b0;
                        if (rd_row < ROWS_END) begin
                            addr_n = ADDR_W'(READ_BASE) + ADDR_W'(rd_row);
                        end
                    end
                    if (rd_row == ROWS_END) begin
                        state_n = ST_DONE;
                    end else begin
                        ph_n = PH_W'(1);
                    end
                end else begin
                    cen_n  = 1'b0;
                    trig_n = 1'b1;
                    fc_n   = 3'(rd_row);
                    if (rd_phase == PH_LAST) begin
                        ph_n  = '0;
                        row_n = rd_row + ROW_W'(1);
                    end else begin
                        ph_n = rd_phase + PH_W'(1);
                    end
                end
            end

            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_bnn_load_seq.sv
// Randomized bench for bnn_load_seq with small image sizes. Expected outputs
// come from a closed-form timeline of a pass indexed by cycles since START.
module tb_bnn_load_seq;

    localparam int I_WORDS  = 3;
    localparam int D_WORDS  = 4;
    localparam int RUN_CYC  = 10;
    localparam int SL       = 41;
    localparam int RB       = 2000;
    localparam int RA       = 5000;
    localparam int ROWS     = 8;
    localparam int ROWLEN   = 34;
    localparam int LOAD_END = (I_WORDS + D_WORDS) * SL;
    localparam int RO_START = LOAD_END + RUN_CYC;
    localparam int PASS_LEN = RO_START + ROWLEN * ROWS + 1;

    logic        CLK;
    logic        RST;
    logic        START;
    logic        BUSY, DONE, PAUSE, SRAMSEL, SRAMMUX;
    logic [13:0] SRAMA;
    logic        SRAMCEN, SRAMWEN, PS_LOADN, TRIGGER;
    logic [2:0]  FC_ROW;

    int vectors     = 0;
    int miscompares = 0;

    // model: mode 0 = idle after reset, 1 = pass in progress, 2 = done
    int m_mode      = 0;
    int m_t         = 0;
    bit m_from_done = 0;

    bnn_load_seq #(
        .INST_WORDS (I_WORDS),
        .DATA_WORDS (D_WORDS),
        .RUN_CYCLES (RUN_CYC)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .START    (START),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .PAUSE    (PAUSE),
        .SRAMSEL  (SRAMSEL),
        .SRAMMUX  (SRAMMUX),
        .SRAMA    (SRAMA),
        .SRAMCEN  (SRAMCEN),
        .SRAMWEN  (SRAMWEN),
        .PS_LOADN (PS_LOADN),
        .TRIGGER  (TRIGGER),
        .FC_ROW   (FC_ROW)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t (pass cycle %0d): observed %h, expected %h",
                     tag, $time, m_t, observed, expected);
        end
    endtask

    // Expected {BUSY,DONE,PAUSE,SRAMSEL,SRAMMUX,SRAMCEN,SRAMWEN,PS_LOADN,TRIGGER,FC_ROW,SRAMA}
    function automatic logic [31:0] modelOuts();
        logic busy, done, pause, sel, mux, cen, wen, psl, trig;
        logic [2:0] fc;
        int sa, u, p, w, c, k, cen_len;
        busy = 0; done = 0; pause = 1; sel = 1; mux = 0; cen = 1;
        wen = 0; psl = 1; trig = 0; fc = 0; sa = 0;
        if (m_mode != 0) begin
            u    = (m_mode == 2) ? PASS_LEN - 1 : m_t - 1;
            busy = (m_mode == 1);
            done = (m_mode == 2);
            if (m_from_done) begin
                fc  = 3'd7;
                sa  = RB + ROWS - 1;
                wen = 1;
            end
            if (u < 0) begin
                mux = 0;
            end else if (u < LOAD_END) begin
                w = u / SL;
                p = u % SL;
                if (w < I_WORDS) begin
                    cen_len = 17; mux = 0; sa = w;
                end else begin
                    cen_len = 33; mux = 1; sa = w - I_WORDS;
                end
                psl = !(p >= 3 && p <= SL - 2);
                cen = !(p >= 5 && p < 5 + cen_len);
                if (u >= SL - 1) wen = 0;
                if (p == SL - 1 && w == I_WORDS - 1) mux = 1;
                if (p == SL - 1 && w == I_WORDS + D_WORDS - 1) begin
                    pause = 0; sel = 0; sa = RA;
                end
            end else if (u < RO_START) begin
                mux = 1; wen = 0; pause = 0; sel = 0; sa = RA;
            end else begin
                c = u - RO_START;
                mux = 1; pause = 1; sel = 1; wen = 1;
                if (c == 0) begin
                    sa = RB; fc = 0;
                end else if (c % ROWLEN != 0) begin
                    cen = 0; trig = 1; fc = 3'(c / ROWLEN); sa = RB + c / ROWLEN;
                end else begin
                    k  = c / ROWLEN;
                    fc = 3'(k - 1);
                    sa = RB + ((k < ROWS) ? k : ROWS - 1);
                end
            end
        end
        return {6'd0, busy, done, pause, sel, mux, cen, wen, psl, trig, fc, sa[13:0]};
    endfunction

    // Drive one cycle of inputs, advance the model across the edge, compare
    task automatic applyStimulus(input logic st, input logic rs);
        logic [31:0] exp_v, obs_v;
        START = st;
        RST   = rs;
        @(posedge CLK);
        #1;
        if (rs) begin
            m_mode = 0;
        end else if (m_mode != 1) begin
            if (st) begin
                m_from_done = (m_mode == 2);
                m_mode      = 1;
                m_t         = 0;
            end
        end else begin
            m_t++;
            if (m_t == PASS_LEN) m_mode = 2;
        end
        exp_v = modelOuts();
        obs_v = {6'd0, BUSY, DONE, PAUSE, SRAMSEL, SRAMMUX, SRAMCEN, SRAMWEN,
                 PS_LOADN, TRIGGER, FC_ROW, SRAMA};
        checkOutput("sram_a", {18'd0, obs_v[13:0]}, {18'd0, exp_v[13:0]});
        checkOutput("ctrl", {6'd0, obs_v[25:14], 14'd0}, {6'd0, exp_v[25:14], 14'd0});
    endtask

    // One pass from START; stray STARTs are sprinkled in; abort_at >= 0 resets there
    task automatic runPass(input int abort_at);
        logic st, rs;
        bit aborted;
        aborted = 0;
        applyStimulus(1'b1, 1'b0);
        for (int cyc = 0; cyc < PASS_LEN + 8; cyc++) begin
            if (m_mode != 1) break;
            rs = (abort_at >= 0 && m_t == abort_at);
            st = !rs && ($urandom_range(0, 15) == 0);
            applyStimulus(st, rs);
            if (rs) begin
                aborted = 1;
                break;
            end
        end
        applyStimulus(1'b0, 1'b0);
        if (aborted)
            checkOutput("abort_idle", {30'd0, DONE, BUSY}, 32'd0);
        else
            checkOutput("pass_done", {30'd0, DONE, BUSY}, 32'd2);
    endtask

    initial begin
        START = 1'b0;
        RST   = 1'b1;
        repeat (3) applyStimulus(1'b0, 1'b1);
        repeat (2 + $urandom_range(0, 4)) applyStimulus(1'b0, 1'b0);

        runPass(-1);
        repeat ($urandom_range(2, 6)) applyStimulus(1'b0, 1'b0);

        runPass(I_WORDS * SL + 2 * SL + 20);
        repeat ($urandom_range(1, 4)) applyStimulus(1'b0, 1'b0);

        runPass(-1);
        runPass(-1);
        runPass(int'($urandom_range(0, PASS_LEN - 2)));
        repeat (3) applyStimulus(1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
